// File: rtl/mem_pkg.sv
// mem_pkg: constants and state encoding shared by the data-RAM arbiter.
//   AW, DW : default address and data widths of the 64x16 data RAM.
//   state_e: arbiter FSM state encoding.
package mem_pkg;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_CPU = 3'd1,
    ACC_AUX = 3'd2,
    ACK_CPU = 3'd3,
    ACK_AUX = 3'd4
  } state_e;

endpackage

// File: rtl/starve_counter.sv
// starve_counter: a saturating counter of consecutive CPU grants taken while
// the aux port was waiting.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, clears the count
//   inc_i      : count one more CPU grant (saturates at LIMIT)
//   clr_i      : clear the count (wins over inc_i)
//   at_limit_o : count has reached LIMIT, aux must be served next
module starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous-read data RAM between the CPU data
// port (priority) and an auxiliary port. Each access takes three cycles:
// IDLE (arbitrate) -> ACC (RAM strobe) -> ACK (ack pulse, read data capture).
// The aux port is forced in after STARVE_MAX consecutive CPU grants made
// while it was waiting.
// Ports:
//   clk_main, reset          : clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU request and operands, held until cpu_ack
//   cpu_rdata, cpu_ack       : CPU read data (valid with ack, then held), ack
//   aux_*                    : same set for the aux port
//   ram_en/we/addr/wdata     : registered RAM command, zero outside ACC
//   ram_rdata                : RAM read data, valid the cycle after ram_en
module ram_arbiter #(
  parameter int unsigned AW         = mem_pkg::AW,
  parameter int unsigned DW         = mem_pkg::DW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  import mem_pkg::*;

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  state_e        state_q;
  logic          grant_we_q;   // we of the access in flight
  logic          ram_en_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          cpu_ack_q;
  logic          aux_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] aux_rdata_q;

  logic aux_go;
  logic cpu_go;
  logic starve_inc;
  logic starve_clr;
  logic starve_at_limit;

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    aux_go = (state_q == IDLE) && aux_req && (starve_at_limit || !cpu_req);
    cpu_go = (state_q == IDLE) && !aux_go && cpu_req;
  end

  // Count CPU grants that bypassed a waiting aux; any cycle without an aux
  // request, or an aux grant, restarts the count.
  assign starve_inc = cpu_go && aux_req;
  assign starve_clr = aux_go || !aux_req;

  starve_counter #(
    .LIMIT (STARVE_MAX),
    .CW    (CW)
  ) u_starve (
    .clk_i      (clk_main),
    .rst_i      (reset),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .at_limit_o (starve_at_limit)
  );

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_we_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      // RAM command and acks are single-cycle; only the transition into an
      // ACC/ACK state raises them.
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aux_go) begin
            state_q     <= ACC_AUX;
            grant_we_q  <= aux_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= aux_we;
            ram_addr_q  <= aux_addr;
            ram_wdata_q <= aux_wdata;
          end else if (cpu_go) begin
            state_q     <= ACC_CPU;
            grant_we_q  <= cpu_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= cpu_we;
            ram_addr_q  <= cpu_addr;
            ram_wdata_q <= cpu_wdata;
          end
        end
        ACC_CPU: begin
          state_q   <= ACK_CPU;
          cpu_ack_q <= 1'b1;
        end
        ACC_AUX: begin
          state_q   <= ACK_AUX;
          aux_ack_q <= 1'b1;
        end
        ACK_CPU: begin
          state_q <= IDLE;
          if (!grant_we_q) begin
            cpu_rdata_q <= ram_rdata;
          end
        end
        ACK_AUX: begin
          state_q <= IDLE;
          if (!grant_we_q) begin
            aux_rdata_q <= ram_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM's own output register supplies read data during ACK, so it is
  // forwarded there to make rdata valid together with ack; the holding
  // register keeps it afterwards.
  assign cpu_rdata = (state_q == ACK_CPU && !grant_we_q) ? ram_rdata : cpu_rdata_q;
  assign aux_rdata = (state_q == ACK_AUX && !grant_we_q) ? ram_rdata : aux_rdata_q;

  assign cpu_ack   = cpu_ack_q;
  assign aux_ack   = aux_ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural
// 64x16 synchronous-read RAM.
module tb_ram_arbiter;

  logic        clk_main;
  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [5:0]  cpu_addr, aux_addr;
  logic [15:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
  logic        cpu_ack, aux_ack;
  logic        ram_en, ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  // Backdoor preload port of the RAM model.
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  ram_arbiter #(.AW(6), .DW(16), .STARVE_MAX(4)) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .aux_req   (aux_req),
    .aux_we    (aux_we),
    .aux_addr  (aux_addr),
    .aux_wdata (aux_wdata),
    .aux_rdata (aux_rdata),
    .aux_ack   (aux_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  initial ram_rdata = 16'h0;
  always @(posedge clk_main) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] aux_order;
    aux_order = 6'b010000;  // grant 4 (0-based) goes to aux

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    pre_we = 1; pre_addr = 6'd5; pre_data = 16'hBEEF;
    step();
    pre_we = 0;
    step();

    // Reset state
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    $display("reset: outputs checked");

    // CPU read of RAM[5]
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd5;
    step();
    chk("cpurd_ram_en", ram_en, 1);
    chk("cpurd_ram_addr", ram_addr, 5);
    chk("cpurd_ram_we", ram_we, 0);
    step();
    chk("cpurd_ack", cpu_ack, 1);
    chk("cpurd_rdata", cpu_rdata, 16'hBEEF);
    chk("cpurd_aux_ack", aux_ack, 0);
    chk("cpurd_ram_en_off", ram_en, 0);
    cpu_req = 0;
    step();
    chk("cpurd_ack_gone", cpu_ack, 0);
    chk("cpurd_rdata_held", cpu_rdata, 16'hBEEF);
    $display("cpu read addr 5: rdata=0x%0h", cpu_rdata);

    // Aux write 63 <- 0x1234
    aux_req = 1; aux_we = 1; aux_addr = 6'd63; aux_wdata = 16'h1234;
    step();
    chk("auxwr_ram_we", ram_we, 1);
    chk("auxwr_ram_addr", ram_addr, 63);
    chk("auxwr_ram_wdata", ram_wdata, 16'h1234);
    step();
    chk("auxwr_ram_we_off", ram_we, 0);
    chk("auxwr_ack", aux_ack, 1);
    chk("auxwr_rdata_unch", aux_rdata, 0);
    aux_req = 0; aux_we = 0;
    step();
    chk("auxwr_ack_gone", aux_ack, 0);
    $display("aux write addr 63 data 0x1234");

    // Aux read back of 63
    aux_req = 1; aux_addr = 6'd63;
    step();
    step();
    chk("auxrd_ack", aux_ack, 1);
    chk("auxrd_rdata", aux_rdata, 16'h1234);
    aux_req = 0;
    step();
    chk("auxrd_rdata_held", aux_rdata, 16'h1234);
    $display("aux read addr 63: rdata=0x%0h", aux_rdata);

    // Both requesting continuously: CPU x4, AUX, CPU
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd5;
    aux_req = 1; aux_we = 0; aux_addr = 6'd63;
    for (int g = 0; g < 6; g++) begin
      step();
      chk($sformatf("both%0d_ram_en", g), ram_en, 1);
      chk($sformatf("both%0d_addr", g), ram_addr, aux_order[g] ? 32'd63 : 32'd5);
      step();
      chk($sformatf("both%0d_cpu_ack", g), cpu_ack, !aux_order[g]);
      chk($sformatf("both%0d_aux_ack", g), aux_ack, aux_order[g]);
      chk($sformatf("both%0d_no_overlap", g), cpu_ack & aux_ack, 0);
      step();
      chk($sformatf("both%0d_idle", g), ram_en, 0);
      $display("grant %0d: %s", g, aux_order[g] ? "AUX" : "CPU");
    end
    cpu_req = 0; aux_req = 0;
    step();

    // Aux alone is granted at once; count stays clear so CPU then wins a tie
    aux_req = 1; aux_addr = 6'd63;
    step();
    chk("auxonly_ram_en", ram_en, 1);
    chk("auxonly_addr", ram_addr, 63);
    step();
    chk("auxonly_ack", aux_ack, 1);
    cpu_req = 1; cpu_addr = 6'd5;  // aux still requesting: a tie next IDLE
    step();
    step();
    chk("tie_after_aux_addr", ram_addr, 5);
    cpu_req = 0; aux_req = 0;
    step();
    step();
    $display("aux alone granted, following tie went to CPU");

    // Reset during ACC_CPU
    cpu_req = 1; cpu_addr = 6'd5;
    step();
    chk("rstmid_ram_en_pre", ram_en, 1);
    reset = 1;
    #1;
    chk("rstmid_ram_en", ram_en, 0);
    chk("rstmid_ram_addr", ram_addr, 0);
    chk("rstmid_cpu_rdata", cpu_rdata, 0);
    chk("rstmid_aux_rdata", aux_rdata, 0);
    step();
    chk("rstmid_no_ack", cpu_ack, 0);
    reset = 0;
    step();
    chk("rstmid_re_en", ram_en, 1);
    step();
    chk("rstmid_re_ack", cpu_ack, 1);
    chk("rstmid_re_rdata", cpu_rdata, 16'hBEEF);
    cpu_req = 0;
    step();
    $display("reset mid-access: cut and recovered");

    // Request withdrawn after grant
    cpu_req = 1; cpu_addr = 6'd5;
    step();
    chk("wd_ram_en", ram_en, 1);
    cpu_req = 0;
    step();
    chk("wd_ack", cpu_ack, 1);
    step();
    chk("wd_idle_en", ram_en, 0);
    step();
    chk("wd_no_second", ram_en, 0);
    chk("wd_no_second_ack", cpu_ack, 0);
    $display("withdrawn request: single ack, no repeat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 64x16 data RAM between two requesters: the CPU memory port (primary) and an auxiliary port (debug loader / display readback).
- Sits between CPU data-memory outputs, the aux master and the RAM macro; the RAM sees exactly one master per access.
- Fixed priority to CPU, with a starvation limiter guaranteeing aux forward progress.
- Per-requester req/ack handshake.

Parameters:
- AW, 6, RAM address width.
- DW, 16, RAM data width.
- STARVE_MAX, 4, consecutive CPU grants allowed while aux_req is pending before aux is forced in (legal range 1..15).

Ports:
- clk_main  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  CPU access request; held with operands until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered read data, valid when cpu_ack=1, held afterward
- cpu_ack  out  1  one-cycle completion pulse
- aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack: same widths and semantics for the aux port
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable (only with ram_en)
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en (synchronous read)

Behaviour:
- FSM states: IDLE, ACC_CPU, ACC_AUX, ACK_CPU, ACK_AUX.
- Reset (async): state=IDLE, starve_cnt=0, every output 0 (including cpu_rdata and aux_rdata).
- IDLE arbitration each cycle:
  - aux_req && (starve_cnt==STARVE_MAX || !cpu_req) -> ACC_AUX.
  - else cpu_req -> ACC_CPU.
  - else stay in IDLE.
- ACC_x: one cycle. ram_en=1, ram_we=x_we, ram_addr=x_addr, ram_wdata=x_wdata. Next state ACK_x.
- ACK_x: one cycle. x_ack=1. If the access was a read, x_rdata<=ram_rdata. If it was a write, x_rdata is unchanged. Next state IDLE.
- Timing:
  - Request seen in IDLE at cycle N -> RAM strobe at N+1 -> ack at N+2.
  - Back-to-back accesses: one per 3 cycles.
  - ram_en=0 and ram_we=0 in IDLE and ACK states. ram_addr/ram_wdata = 0 when not in an ACC state.
- Operand latching: the arbiter latches x_we into the grant register on IDLE->ACC so ACK_x knows read vs write.
- Starvation counter:
  - starve_cnt increments on every IDLE->ACC_CPU transition taken while aux_req=1, saturating at STARVE_MAX.
  - Clears to 0 on IDLE->ACC_AUX, or in any cycle where aux_req=0.
- Requester rules:
  - Requester must hold req and operands stable until its ack.
  - Requester must deassert req in the cycle after ack if it has no further access; a req still high in IDLE is a new request.
  - Req dropped mid-access: the access still completes and ack still pulses.
- Simultaneous requests: CPU wins unless starve_cnt==STARVE_MAX.
- Only one ack is asserted in any cycle; cpu_ack and aux_ack are never high together.
- Reset mid-access: the RAM strobe (if in ACC) is cut immediately and no ack is issued. Requesters re-request after reset.
- No combinational path from req to ram_*; all ram_* and ack outputs are driven from registered state.

Decomposition:
- Shared package `mem_pkg`: AW and DW constants, state encoding (IDLE=3'd0, ACC_CPU=3'd1, ACC_AUX=3'd2, ACK_CPU=3'd3, ACK_AUX=3'd4).
- One natural sub-module: `starve_counter`, a saturating counter with inc/clr/limit-flag, width ceil(log2(STARVE_MAX+1)).
- FSM and muxing stay in ram_arbiter.

Test Plan:
- Reset, then CPU read only: preload RAM[5]=16'hBEEF; cpu_req=1, cpu_we=0, cpu_addr=5 at cycle 0 -> ram_en=1/ram_addr=5 at cycle 1, cpu_ack=1 and cpu_rdata=16'hBEEF at cycle 2, aux_ack stays 0.
- Aux write then read-back:
  - aux write addr=63, data=16'h1234 -> ram_we=1 for exactly one cycle, aux_ack one cycle later, aux_rdata unchanged.
  - Subsequent aux read of addr 63 -> aux_rdata=16'h1234.
- Simultaneous req, STARVE_MAX=4: cpu_req and aux_req held high continuously -> grant order CPU,CPU,CPU,CPU,AUX,CPU... One access per 3 cycles; cpu_ack and aux_ack never overlap.
- Aux alone while CPU idle: aux_req=1, cpu_req=0 -> aux granted immediately; starve_cnt stays 0.
- Reset mid-access: assert reset during ACC_CPU -> ram_en falls in the same cycle, no cpu_ack, all outputs 0. After release, a fresh cpu_req completes normally in 3 cycles.
- Req withdrawn after grant: cpu_req drops in ACC_CPU -> cpu_ack still pulses at the ACK cycle, then FSM returns to IDLE and no second access occurs.
